// File: rtl/reg_file_param_if.sv
// -----------------------------------------------------------------------------
// reg_file_param_if
// Bus bundle between the pipeline and the parametrised register file.
//   write_en / write_addr / write_value : writeback-stage write port
//   rd_addr  : packed read indices, port k = [k*ADDR_W +: ADDR_W]
//   rd_data  : packed read data,    port k = [k*DATA_W +: DATA_W]
//   ready    : initialisation sweep finished, writes are accepted
//   write_drop : sticky flag, a write was seen before ready
// Modports: master = pipeline side, slave = register file side.
// -----------------------------------------------------------------------------
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       write_en;
    logic [ADDR_W-1:0]          write_addr;
    logic [DATA_W-1:0]          write_value;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic                       ready;
    logic                       write_drop;

    modport master (
        output write_en, write_addr, write_value, rd_addr,
        input  rd_data, ready, write_drop
    );

    modport slave (
        input  write_en, write_addr, write_value, rd_addr,
        output rd_data, ready, write_drop
    );
endinterface

// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
// Parametrised integer register file: NUM_RD combinational read ports, one
// synchronous write port, optional same-cycle write-to-read bypass. After
// reset an initialisation sweep writes every entry (stack pointer entry gets
// SP_INIT, all others zero), so the storage array needs no reset of its own.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (restarts the sweep)
//   bus     : reg_file_param_if.slave (write port, read ports, ready,
//             write_drop)
// -----------------------------------------------------------------------------
module reg_file_param #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_RD   = 2,
    parameter int                ZERO_REG = 1,
    parameter int                SP_INDEX = 2,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(32'h0000_1000),
    parameter int                BYPASS   = 1
) (
    input logic               clk,
    input logic               reset_n,
    reg_file_param_if.slave   bus
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_INDEX);
    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

    // Elaboration-time parameter legality checks
    generate
        if (SP_INDEX < 0 || SP_INDEX >= DEPTH) begin : g_bad_sp_range
            $fatal(1, "reg_file_param: SP_INDEX must be below DEPTH");
        end
        if (ZERO_REG == 1 && SP_INDEX == 0) begin : g_bad_sp_zero
            $fatal(1, "reg_file_param: SP_INDEX must be nonzero when ZERO_REG=1");
        end
        if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
            $fatal(1, "reg_file_param: NUM_RD must be 1..4");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    state_r;
    logic [ADDR_W-1:0]         cnt_r;
    logic                      ready_r;
    logic                      write_drop_r;
    logic [DATA_W-1:0]         mem_r [DEPTH];

    logic                      write_ok_s;
    logic                      mem_we_s;
    logic [ADDR_W-1:0]         mem_waddr_s;
    logic [DATA_W-1:0]         mem_wdata_s;
    logic [NUM_RD*DATA_W-1:0]  rd_data_s;

    // A pipeline write is committed only in RUN and only if it does not target
    // the hardwired zero entry.
    always_comb begin
        write_ok_s = 1'b0;
        if (ready_r && bus.write_en) begin
            if (ZERO_REG == 1 && bus.write_addr == ZERO_IDX) begin
                write_ok_s = 1'b0;
            end else begin
                write_ok_s = 1'b1;
            end
        end else begin
            write_ok_s = 1'b0;
        end
    end

    // Init/run FSM with sweep counter, ready and sticky write_drop flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_INIT;
            cnt_r        <= {ADDR_W{1'b0}};
            ready_r      <= 1'b0;
            write_drop_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + ADDR_W'(1);
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_INIT;
                        ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_INIT;
                    cnt_r   <= {ADDR_W{1'b0}};
                    ready_r <= 1'b0;
                end
            endcase
            // Any write before ready (including the last sweep edge) is lost.
            if (bus.write_en && !ready_r) begin
                write_drop_r <= 1'b1;
            end else begin
                write_drop_r <= write_drop_r;
            end
        end
    end

    // Array write source: the sweep owns the port until ready, then the
    // pipeline write port takes over.
    always_comb begin
        if (state_r == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = (cnt_r == SP_ADDR) ? SP_INIT : {DATA_W{1'b0}};
        end else begin
            mem_we_s    = write_ok_s;
            mem_waddr_s = bus.write_addr;
            mem_wdata_s = bus.write_value;
        end
    end

    // Storage array, deliberately without reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end else begin
            mem_r[mem_waddr_s] <= mem_r[mem_waddr_s];
        end
    end

    // Read ports resolve independently: gate to zero before ready, zero entry,
    // then bypass, then array contents.
    always_comb begin
        rd_data_s = {(NUM_RD*DATA_W){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (!ready_r) begin
                rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if (ZERO_REG == 1 && bus.rd_addr[k*ADDR_W +: ADDR_W] == ZERO_IDX) begin
                rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if (BYPASS == 1 && write_ok_s &&
                         bus.rd_addr[k*ADDR_W +: ADDR_W] == bus.write_addr) begin
                rd_data_s[k*DATA_W +: DATA_W] = bus.write_value;
            end else begin
                rd_data_s[k*DATA_W +: DATA_W] = mem_r[bus.rd_addr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign bus.rd_data    = rd_data_s;
    assign bus.ready      = ready_r;
    assign bus.write_drop = write_drop_r;

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the core integer register file, for the next pipeline generation. It provides NUM_RD combinational read ports, one synchronous write port and optional write-to-read bypass. A post-reset initialisation sweep loads every entry, including the stack-pointer preset, so the array itself carries no reset. It sits between the decode stage (reads) and the writeback stage (writes).

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 hardwired to zero
SP_INDEX, 2, entry preset by the sweep to SP_INIT
SP_INIT, 32'h1000, stack-pointer initial value (DATA_W bits)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
write_en  in  1  write strobe
write_addr  in  ADDR_W  write index
write_value  in  DATA_W  write data
rd_addr  in  NUM_RD*ADDR_W  packed read indices; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
ready  out  1  1 = init sweep done, writes accepted
write_drop  out  1  sticky: a write arrived while ready=0

Behaviour:
- Reset:
  - reset_n low asynchronously forces state=INIT, sweep counter=0, ready=0, write_drop=0.
  - Array contents are not reset.
  - rd_data reads all-zero while ready=0.
- FSM INIT:
  - One entry is written per clk, starting with the first rising edge after reset_n high.
  - Entry cnt is written with SP_INIT if cnt==SP_INDEX, else 0.
  - cnt increments each cycle. On the edge that writes entry DEPTH-1, state becomes RUN and ready=1 from that edge.
  - ready therefore rises exactly DEPTH edges after reset release (32 with defaults).
- FSM RUN:
  - Stays in RUN until reset.
  - On a rising edge with write_en=1, entry[write_addr] takes write_value.
  - Exception: if ZERO_REG=1 and write_addr==0, the write is discarded.
- write_en while ready=0:
  - The write is ignored, including on the final INIT edge.
  - write_drop is set to 1 on that edge and holds until reset.
- Reads:
  - Purely combinational: rd_data_k = entry[rd_addr_k], zero-latency.
  - If ZERO_REG=1 and rd_addr_k==0, rd_data_k=0 regardless of array content.
- Bypass:
  - Applies when BYPASS=1, ready=1, write_en=1, rd_addr_k==write_addr and the write is not discarded.
  - rd_data_k = write_value in the same cycle.
  - With BYPASS=0 the read returns the old value until after the edge.
- Multiple read ports may address the same entry. Each port resolves independently, all reads and bypasses occur in parallel, and there is no port priority.
- Reset asserted mid-sweep or in RUN:
  - Aborts immediately and the sweep restarts from entry 0 after release.
  - A partially written array is never exposed, since reads are 0 until ready.
- Width rules:
  - SP_INIT is truncated or zero-extended to DATA_W.
  - SP_INDEX must be < DEPTH; when ZERO_REG=1 it must also be nonzero. Enforce both with an elaboration-time check.
- No X may reach rd_data after ready=1, since every entry has been written by the sweep.

Test Plan:
- Release reset_n, hold write_en=0 and count edges. ready goes 1 after exactly 32 edges; then rd_addr={5'd2,5'd0} -> rd_data={32'h1000,32'h0}, and every other entry reads 0.
- After ready: write 32'hDEADBEEF to x5, then read x5 on both ports next cycle -> both read 32'hDEADBEEF. Write 32'h1234 to x0 -> x0 still reads 0.
- BYPASS=1: in one cycle write_en=1, write_addr=7, write_value=32'hA5A5A5A5, rd_addr port0=7 -> rd_data0=32'hA5A5A5A5 in the same cycle. Repeat with BYPASS=0 -> old value 0 that cycle, 32'hA5A5A5A5 next.
- Assert write_en with addr 3 during sweep cycle 10 -> write_drop=1 and stays 1. After ready, x3 reads 0. A later reset clears write_drop.
- Pulse reset_n low asynchronously (mid-cycle) at sweep cycle 20 -> ready stays 0 and rd_data stays 0. After release ready rises 32 edges later, with x2=32'h1000.
- Parameter sweep DATA_W=64, ADDR_W=4, NUM_RD=3, ZERO_REG=0: ready after 16 edges. A write to x0 of 64'h1 reads back 64'h1, and three ports reading the same address return identical data.
